// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of imem_loader.
// The loader connects through the slave modport; the stream source and memory side connect through master.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [7:0]        imem_wdata;

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: accepts a framed stream (length, instruction bytes, XOR checksum).
// It writes the instruction bytes to memory and enables core_run after a clean load. Define IMEM_LOADER_PAD_EN to NOP-fill the rest of memory.
module imem_loader #(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic         sysclk,
  input  logic         sysrst_n,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic         core_run,
  output logic [7:0]   loaded_len
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEN   = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERROR = 3'd5;
`ifdef IMEM_LOADER_PAD_EN
  localparam logic [2:0]        S_PAD  = 3'd6;
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);
`endif
  localparam logic [31:0] SPACE = 32'(DEPTH - BASE_ADDR);

  logic [2:0]        state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [7:0]        imem_wdata_q, imem_wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              core_run_q, core_run_d;
  logic [7:0]        loaded_len_q, loaded_len_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        csum_q, csum_d;
  logic [7:0]        cnt_q, cnt_d;
`ifdef IMEM_LOADER_PAD_EN
  logic [ADDR_W-1:0] pad_ptr_q, pad_ptr_d;
`endif
  logic              xfer_s;

  // in_ready mirrors the state, so a transfer is simply valid while ready is up
  assign xfer_s = bus.in_valid & in_ready_q;

  // Next-state and next-output computation for the load sequencer
  always_comb begin
    state_d      = state_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    done_d       = done_q;
    error_d      = error_q;
    core_run_d   = core_run_q;
    loaded_len_d = loaded_len_q;
    len_d        = len_q;
    csum_d       = csum_q;
    cnt_d        = cnt_q;
`ifdef IMEM_LOADER_PAD_EN
    pad_ptr_d    = pad_ptr_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d    = S_LEN;
          done_d     = 1'b0;
          error_d    = 1'b0;
          core_run_d = 1'b0;
          csum_d     = 8'd0;
          cnt_d      = 8'd0;
        end else begin
          state_d = state_q;
        end
      end
      S_LEN: begin
        if (xfer_s) begin
          len_d        = bus.in_data;
          csum_d       = bus.in_data;
          loaded_len_d = bus.in_data;
          if (32'(bus.in_data) > SPACE) begin
            state_d    = S_ERROR;
            error_d    = 1'b1;
            core_run_d = 1'b0;
          end else if (bus.in_data == 8'd0) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_LEN;
        end
      end
      S_LOAD: begin
        if (xfer_s) begin
          imem_we_d    = 1'b1;
          imem_addr_d  = ADDR_W'(32'(BASE_ADDR) + 32'(cnt_q));
          imem_wdata_d = bus.in_data;
          csum_d       = csum_q ^ bus.in_data;
          cnt_d        = cnt_q + 8'd1;
          if ((cnt_q + 8'd1) == len_q) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_LOAD;
        end
      end
      S_CHECK: begin
        if (xfer_s) begin
          if (bus.in_data == csum_q) begin
`ifdef IMEM_LOADER_PAD_EN
            // A frame that fills memory exactly has nothing left to pad
            if ((32'(BASE_ADDR) + 32'(len_q)) == 32'(DEPTH)) begin
              state_d    = S_DONE;
              done_d     = 1'b1;
              core_run_d = 1'b1;
            end else begin
              state_d   = S_PAD;
              pad_ptr_d = ADDR_W'(32'(BASE_ADDR) + 32'(len_q));
            end
`else
            state_d    = S_DONE;
            done_d     = 1'b1;
            core_run_d = 1'b1;
`endif
          end else begin
            state_d    = S_ERROR;
            error_d    = 1'b1;
            core_run_d = 1'b0;
          end
        end else begin
          state_d = S_CHECK;
        end
      end
`ifdef IMEM_LOADER_PAD_EN
      S_PAD: begin
        imem_we_d    = 1'b1;
        imem_addr_d  = pad_ptr_q;
        imem_wdata_d = 8'h00;
        pad_ptr_d    = pad_ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        if (pad_ptr_q == LAST_A) begin
          state_d    = S_DONE;
          done_d     = 1'b1;
          core_run_d = 1'b1;
        end else begin
          state_d = S_PAD;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
    in_ready_d = (state_d == S_LEN) || (state_d == S_LOAD) || (state_d == S_CHECK);
    busy_d     = !((state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_ERROR));
  end

  // State and output registers
  always_ff @(posedge sysclk or negedge sysrst_n) begin
    if (!sysrst_n) begin
      state_q      <= S_IDLE;
      in_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= 8'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      core_run_q   <= 1'b0;
      loaded_len_q <= 8'd0;
      len_q        <= 8'd0;
      csum_q       <= 8'd0;
      cnt_q        <= 8'd0;
`ifdef IMEM_LOADER_PAD_EN
      pad_ptr_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      core_run_q   <= core_run_d;
      loaded_len_q <= loaded_len_d;
      len_q        <= len_d;
      csum_q       <= csum_d;
      cnt_q        <= cnt_d;
`ifdef IMEM_LOADER_PAD_EN
      pad_ptr_q    <= pad_ptr_d;
`endif
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign core_run       = core_run_q;
  assign loaded_len     = loaded_len_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader; with IMEM_LOADER_PAD_EN it runs a DEPTH=8 instance and adds the padding scenarios.
module tb_imem_loader;

`ifdef IMEM_LOADER_PAD_EN
  localparam int DEPTH  = 8;
  localparam int PAD_ON = 1;
`else
  localparam int DEPTH  = 256;
  localparam int PAD_ON = 0;
`endif

  logic       sysclk;
  logic       sysrst_n;
  logic       start;
  logic       busy, done, error, core_run;
  logic [7:0] loaded_len;

  imem_loader_if #(.ADDR_W(8)) bus ();

  imem_loader #(.ADDR_W(8), .DEPTH(DEPTH), .BASE_ADDR(0)) dut (
    .sysclk     (sysclk),
    .sysrst_n   (sysrst_n),
    .start      (start),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .core_run   (core_run),
    .loaded_len (loaded_len)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] frame [0:15];
  int         frame_n;
  bit         vpat [0:7];
  int         vpat_len;

  logic [7:0] wa [$];
  logic [7:0] wd [$];
  int         wc [$];

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  always @(posedge sysclk) cyc <= cyc + 1;

  // Write-strobe log, sampled away from the active edge
  always @(negedge sysclk) begin
    if (bus.imem_we === 1'b1) begin
      wa.push_back(bus.imem_addr);
      wd.push_back(bus.imem_wdata);
      wc.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_log();
    wa.delete();
    wd.delete();
    wc.delete();
  endtask

  task automatic set_frame(input int n, input logic [127:0] bytes);
    frame_n = n;
    for (int i = 0; i < n; i++) frame[i] = bytes[8*(n-1-i) +: 8];
  endtask

  task automatic set_valid_always();
    vpat_len = 1;
    vpat[0]  = 1'b1;
  endtask

  task automatic do_start();
    @(negedge sysclk);
    start = 1'b1;
    @(negedge sysclk);
    start = 1'b0;
  endtask

  // Streams frame[0..frame_n-1], valid following vpat; ok=0 if the budget runs out
  task automatic drive_frame(output bit ok);
    int   i = 0;
    int   k = 0;
    logic rdy;
    while (i < frame_n && k < 300) begin
      @(negedge sysclk);
      bus.in_data  = frame[i];
      bus.in_valid = vpat[k % vpat_len];
      rdy          = bus.in_ready;
      k++;
      @(posedge sysclk);
      if (bus.in_valid && rdy) i++;
    end
    @(negedge sysclk);
    bus.in_valid = 1'b0;
    ok = (i == frame_n);
  endtask

  task automatic wait_end(output bit ok);
    for (int k = 0; k < 2000 && !(done || error); k++) @(negedge sysclk);
    ok = done || error;
    @(negedge sysclk);
  endtask

  task automatic test_reset();
    sysrst_n     = 1'b0;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    #12;
    total++;
    if ({bus.in_ready, bus.imem_we, busy, done, error, core_run} !== 6'b0) begin
      bad++; $display("FAIL reset_flags: got %b want 000000", {bus.in_ready, bus.imem_we, busy, done, error, core_run});
    end
    total++;
    if ({bus.imem_addr, bus.imem_wdata, loaded_len} !== 24'h0) begin
      bad++; $display("FAIL reset_buses: got %h want 000000", {bus.imem_addr, bus.imem_wdata, loaded_len});
    end
    @(negedge sysclk);
    sysrst_n = 1'b1;
    @(negedge sysclk);
    @(negedge sysclk);
    total++;
    if ({bus.in_ready, busy, done} !== 3'b0) begin
      bad++; $display("FAIL idle_after_reset: got %b want 000", {bus.in_ready, busy, done});
    end
  endtask

  task automatic test_basic();
    bit ok;
    logic [7:0] exp_d [0:2];
    exp_d[0] = 8'h21; exp_d[1] = 8'h4A; exp_d[2] = 8'h83;
    clear_log();
    set_frame(5, {8'h03, 8'h21, 8'h4A, 8'h83, 8'hEB});
    set_valid_always();
    do_start();
    drive_frame(ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_drive: got timeout want frame accepted"); end
    wait_end(ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_end: got timeout want done"); end
    total++;
    if (wa.size() !== 3 + PAD_ON * (DEPTH - 3)) begin
      bad++; $display("FAIL basic_wcount: got %0d want %0d", wa.size(), 3 + PAD_ON * (DEPTH - 3));
    end
    for (int j = 0; j < 3; j++) begin
      total++;
      if (wa[j] !== 8'(j) || wd[j] !== exp_d[j]) begin
        bad++; $display("FAIL basic_write%0d: got (%0h,%h) want (%0h,%h)", j, wa[j], wd[j], j, exp_d[j]);
      end
    end
    total++;
    if (wc[1] !== wc[0] + 1 || wc[2] !== wc[0] + 2) begin
      bad++; $display("FAIL basic_b2b: got cycles %0d,%0d,%0d want consecutive", wc[0], wc[1], wc[2]);
    end
    total++;
    if ({done, core_run, error, busy, bus.in_ready} !== 5'b11000 || loaded_len !== 8'd3) begin
      bad++; $display("FAIL basic_status: got %b len=%0d want 11000 len=3", {done, core_run, error, busy, bus.in_ready}, loaded_len);
    end
    total++;
    if (bus.imem_addr !== 8'(PAD_ON != 0 ? DEPTH - 1 : 2)) begin
      bad++; $display("FAIL basic_addr_hold: got %0h want %0h", bus.imem_addr, PAD_ON != 0 ? DEPTH - 1 : 2);
    end
  endtask

  task automatic test_bad_csum();
    bit ok;
    clear_log();
    set_frame(5, {8'h03, 8'h21, 8'h4A, 8'h83, 8'h00});
    set_valid_always();
    do_start();
    total++;
    if ({done, core_run, busy, bus.in_ready} !== 4'b0011) begin
      bad++; $display("FAIL restart_from_done: got %b want 0011", {done, core_run, busy, bus.in_ready});
    end
    drive_frame(ok);
    wait_end(ok);
    total++; if (!ok) begin bad++; $display("FAIL badcs_end: got timeout want error"); end
    total++;
    if (wa.size() !== 3 || wd[2] !== 8'h83) begin
      bad++; $display("FAIL badcs_writes: got %0d writes last=%h want 3 last=83", wa.size(), wd[2]);
    end
    total++;
    if ({error, done, core_run, busy} !== 4'b1000) begin
      bad++; $display("FAIL badcs_status: got %b want 1000", {error, done, core_run, busy});
    end
  endtask

  task automatic test_zero_len();
    bit ok;
    clear_log();
    set_frame(2, {8'h00, 8'h00});
    set_valid_always();
    do_start();
    total++; if (error !== 1'b0) begin bad++; $display("FAIL restart_from_error: got error=%b want 0", error); end
    drive_frame(ok);
    wait_end(ok);
    total++; if (!ok) begin bad++; $display("FAIL zero_end: got timeout want done"); end
    total++;
    if (wa.size() !== PAD_ON * DEPTH) begin
      bad++; $display("FAIL zero_wcount: got %0d want %0d", wa.size(), PAD_ON * DEPTH);
    end
    total++;
    if ({done, core_run, error} !== 3'b110 || loaded_len !== 8'd0) begin
      bad++; $display("FAIL zero_status: got %b len=%0d want 110 len=0", {done, core_run, error}, loaded_len);
    end
  endtask

  task automatic test_valid_toggle();
    bit ok;
    logic [7:0] exp_d [0:2];
    exp_d[0] = 8'h21; exp_d[1] = 8'h4A; exp_d[2] = 8'h83;
    clear_log();
    set_frame(5, {8'h03, 8'h21, 8'h4A, 8'h83, 8'hEB});
    vpat_len = 6;
    vpat[0] = 1'b1; vpat[1] = 1'b0; vpat[2] = 1'b0; vpat[3] = 1'b1; vpat[4] = 1'b0; vpat[5] = 1'b1;
    do_start();
    drive_frame(ok);
    wait_end(ok);
    total++; if (!ok) begin bad++; $display("FAIL toggle_end: got timeout want done"); end
    total++;
    if (wa.size() !== 3 + PAD_ON * (DEPTH - 3)) begin
      bad++; $display("FAIL toggle_wcount: got %0d want %0d", wa.size(), 3 + PAD_ON * (DEPTH - 3));
    end
    for (int j = 0; j < 3; j++) begin
      total++;
      if (wa[j] !== 8'(j) || wd[j] !== exp_d[j]) begin
        bad++; $display("FAIL toggle_write%0d: got (%0h,%h) want (%0h,%h)", j, wa[j], wd[j], j, exp_d[j]);
      end
    end
    total++;
    if (wc[1] === wc[0] + 1) begin
      bad++; $display("FAIL toggle_gap: got write cycles %0d,%0d want a gap", wc[0], wc[1]);
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL toggle_done: got %b want 1", done); end
  endtask

  task automatic test_start_ignored();
    bit ok;
    clear_log();
    set_valid_always();
    set_frame(2, {8'h03, 8'h21});
    do_start();
    drive_frame(ok);
    @(negedge sysclk);
    start = 1'b1;
    @(negedge sysclk);
    start = 1'b0;
    set_frame(3, {8'h4A, 8'h83, 8'hEB});
    drive_frame(ok);
    total++; if (!ok) begin bad++; $display("FAIL ignstart_drive: got timeout want frame accepted"); end
    wait_end(ok);
    total++;
    if (done !== 1'b1 || wa.size() < 3 || wa[2] !== 8'd2 || wd[2] !== 8'h83) begin
      bad++; $display("FAIL ignstart_result: got done=%b n=%0d want done=1 third write (2,83)", done, wa.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_log();
    set_valid_always();
    set_frame(3, {8'h03, 8'h21, 8'h4A});
    do_start();
    drive_frame(ok);
    #2;
    total++;
    if (wa.size() !== 2 || bus.imem_addr !== 8'd1) begin
      bad++; $display("FAIL midrst_pre: got %0d writes addr=%0h want 2 addr=1", wa.size(), bus.imem_addr);
    end
    sysrst_n = 1'b0;
    #1;
    total++;
    if ({bus.in_ready, bus.imem_we, busy, done, error, core_run} !== 6'b0 ||
        {bus.imem_addr, bus.imem_wdata, loaded_len} !== 24'h0) begin
      bad++; $display("FAIL midrst_outputs: got %b %h want all zero",
                      {bus.in_ready, bus.imem_we, busy, done, error, core_run}, {bus.imem_addr, bus.imem_wdata, loaded_len});
    end
    @(negedge sysclk);
    sysrst_n = 1'b1;
    clear_log();
    set_frame(5, {8'h03, 8'h21, 8'h4A, 8'h83, 8'hEB});
    do_start();
    drive_frame(ok);
    wait_end(ok);
    total++;
    if (done !== 1'b1 || wa.size() < 3 || wd[0] !== 8'h21 || wd[1] !== 8'h4A || wa[2] !== 8'd2) begin
      bad++; $display("FAIL midrst_reload: got done=%b n=%0d want done=1 writes 21,4A at 0..2", done, wa.size());
    end
  endtask

`ifdef IMEM_LOADER_PAD_EN
  task automatic test_pad();
    bit ok;
    int viol = 0;
    int pcyc = 0;
    clear_log();
    set_valid_always();
    set_frame(5, {8'h03, 8'h21, 8'h4A, 8'h83, 8'hEB});
    do_start();
    drive_frame(ok);
    while (!done && pcyc < 100) begin
      if (bus.in_ready !== 1'b0 || busy !== 1'b1) viol++;
      pcyc++;
      @(negedge sysclk);
    end
    @(negedge sysclk);
    total++;
    if (viol !== 0 || pcyc !== 5) begin
      bad++; $display("FAIL pad_phase: got viol=%0d cycles=%0d want 0 and 5", viol, pcyc);
    end
    for (int j = 3; j < 8; j++) begin
      total++;
      if (wa[j] !== 8'(j) || wd[j] !== 8'h00 || wc[j] !== wc[2] + (j - 2)) begin
        bad++; $display("FAIL pad_write%0d: got (%0h,%h) want (%0h,00)", j, wa[j], wd[j], j);
      end
    end
    // A length that fills memory exactly skips padding
    clear_log();
    set_frame(10, {8'h08, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h00});
    do_start();
    drive_frame(ok);
    wait_end(ok);
    total++;
    if (done !== 1'b1 || wa.size() !== 8 || wd[7] !== 8'h08) begin
      bad++; $display("FAIL pad_full: got done=%b n=%0d want done=1 n=8", done, wa.size());
    end
    clear_log();
    set_frame(1, {8'h09});
    do_start();
    drive_frame(ok);
    wait_end(ok);
    total++;
    if (error !== 1'b1 || wa.size() !== 0 || loaded_len !== 8'd9) begin
      bad++; $display("FAIL pad_toolong: got error=%b n=%0d len=%0d want 1 0 9", error, wa.size(), loaded_len);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_bad_csum();
    test_zero_len();
    test_valid_toggle();
    test_start_ignored();
    test_reset_mid();
`ifdef IMEM_LOADER_PAD_EN
    test_pad();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
